// File: rtl/para_serializer.sv
// para_serializer: unpacks IN_WIDTH host beats into PARA_WIDTH words for para_loader, lane 0 first.
// Lane 0 appears 1 cycle after accept; host_ready only while the one-beat buffer is empty or on its last lane.
module para_serializer #(
  parameter int IN_WIDTH    = 64,
  parameter int PARA_WIDTH  = 16,
  parameter int FM_DEPTH    = 64,
  parameter int CHANNEL_NUM = 128,
  parameter int PARA_NUM    = 6
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         host_valid,
  input  logic [IN_WIDTH-1:0]          host_data,
  output logic                         host_ready,
  output logic signed [PARA_WIDTH-1:0] para_out,
  output logic                         data_out_valid,
  output logic                         mode_out,
  output logic                         busy,
  output logic                         load_done
);
  localparam int LANES = IN_WIDTH / PARA_WIDTH;
  localparam int TOTAL = FM_DEPTH + (PARA_NUM - 1) * CHANNEL_NUM;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW    = $clog2(TOTAL + LANES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state_q, state_d;

  logic [LANES-1:0][PARA_WIDTH-1:0] buf_dat;
  logic [LW-1:0] lane_cnt, nxt_lane;
  logic [CW-1:0] word_cnt, committed;
  logic          buf_full, last_lane, final_word, accept;
  logic          mode_d, busy_d, done_d;

  // The output valid flag doubles as the buffer occupancy flag.
  assign buf_full   = data_out_valid;
  assign last_lane  = (lane_cnt == LW'(LANES - 1));
  assign nxt_lane   = lane_cnt + LW'(1);
  assign committed  = word_cnt + (buf_full ? (CW'(LANES) - CW'(lane_cnt)) : '0);
  assign final_word = buf_full && (word_cnt == CW'(TOTAL - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (final_word) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    host_ready = (state_q == LOAD) && (!buf_full || last_lane) && (committed < CW'(TOTAL));
    accept     = host_valid && host_ready;
    mode_d     = (state_d != LOAD);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_out  <= 1'b1;
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      mode_out  <= mode_d;
      busy      <= busy_d;
      load_done <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_dat        <= '0;
      lane_cnt       <= '0;
      word_cnt       <= '0;
      para_out       <= '0;
      data_out_valid <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        word_cnt       <= '0;
        lane_cnt       <= '0;
        data_out_valid <= 1'b0;
      end
    end else if (state_q == LOAD) begin
      if (buf_full) word_cnt <= word_cnt + CW'(1);
      // Leftover lanes of the final beat are dropped here.
      if (final_word) begin
        data_out_valid <= 1'b0;
      end else if (accept) begin
        buf_dat        <= host_data;
        para_out       <= host_data[PARA_WIDTH-1:0];
        lane_cnt       <= '0;
        data_out_valid <= 1'b1;
      end else if (buf_full && !last_lane) begin
        lane_cnt <= nxt_lane;
        para_out <= buf_dat[nxt_lane];
      end else begin
        data_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_para_serializer.sv
// Bench for para_serializer: expected word stream is built from the offered beats in order,
// independent of handshake timing; status outputs are checked against the load sequence.
module tb_para_serializer;
  localparam int PW    = 16;
  localparam int LANES = 64 / 16;
  localparam int TOTAL = 64 + (6 - 1) * 128;
  localparam int NB    = TOTAL / LANES;

  logic               clk = 1'b0;
  logic               rstn, start, host_valid;
  logic [63:0]        host_data;
  logic               host_ready, data_out_valid, mode_out, busy, load_done;
  logic signed [15:0] para_out;
  integer             total = 0, bad = 0;

  always #5 clk = ~clk;

  para_serializer #(.IN_WIDTH(64), .PARA_WIDTH(16), .FM_DEPTH(64), .CHANNEL_NUM(128), .PARA_NUM(6)) dut (
    .clk(clk), .rstn(rstn), .start(start), .host_valid(host_valid), .host_data(host_data),
    .host_ready(host_ready), .para_out(para_out), .data_out_valid(data_out_valid),
    .mode_out(mode_out), .busy(busy), .load_done(load_done)
  );

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; host_valid = 1'b0; host_data = '0;
    repeat (3) @(negedge clk);
    total++;
    if (mode_out !== 1'b1 || data_out_valid !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 ||
        para_out !== 16'sd0 || host_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: mode=%b dov=%b busy=%b done=%b para=%0d rdy=%b, want 1 0 0 0 0 0",
               mode_out, data_out_valid, busy, load_done, para_out, host_ready);
    end
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      host_valid = 1'b1; host_data = {$urandom, $urandom};
      @(negedge clk);
      total++;
      if (host_ready !== 1'b0 || data_out_valid !== 1'b0) begin
        bad++; $display("FAIL idle_ignore cycle %0d: rdy=%b dov=%b, want 0 0", i, host_ready, data_out_valid);
      end
    end
    host_valid = 1'b0;
    total++;
    if (mode_out !== 1'b1 || para_out !== 16'sd0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_state: mode=%b para=%0d busy=%b, want 1 0 0", mode_out, para_out, busy);
    end
  endtask

  // mode 0: back-to-back, 1: valid one cycle in three, 2: random valid.
  task automatic test_stream(input int mode, input bit rand_data, input bit hold_start, input string name);
    logic [63:0] beats [NB];
    logic [15:0] exp_w [TOTAL];
    int bi, nw, acc_cyc, dov_first, dov_last, done_cyc;
    bit offer, seen_done;
    for (int b = 0; b < NB; b++)
      beats[b] = rand_data ? {$urandom, $urandom} : {16'(4*b+3), 16'(4*b+2), 16'(4*b+1), 16'(4*b)};
    for (int w = 0; w < TOTAL; w++) exp_w[w] = beats[w / LANES][(w % LANES) * PW +: PW];
    bi = 0; nw = 0; acc_cyc = -1; dov_first = -1; dov_last = -1; done_cyc = -1; seen_done = 1'b0;
    @(negedge clk); start = 1'b1; host_valid = 1'b0;
    @(negedge clk); if (!hold_start) start = 1'b0;
    total++;
    if (mode_out !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL %s start_enter: mode=%b busy=%b, want 0 1", name, mode_out, busy);
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (data_out_valid === 1'b1) begin
        total++;
        if (nw >= TOTAL) begin
          bad++; $display("FAIL %s extra_word: got %h beyond %0d words", name, para_out, TOTAL);
        end else if (para_out !== exp_w[nw] || mode_out !== 1'b0) begin
          bad++; $display("FAIL %s word %0d: para=%h mode=%b, want %h 0", name, nw, para_out, mode_out, exp_w[nw]);
        end
        if (dov_first < 0) dov_first = cyc;
        dov_last = cyc;
        nw++;
      end
      if (load_done === 1'b1) begin
        seen_done = 1'b1; done_cyc = cyc; host_valid = 1'b0;
        break;
      end
      case (mode)
        0:       offer = (bi < NB);
        1:       offer = (bi < NB) && (cyc % 3 == 0);
        default: offer = (bi < NB) && ($urandom_range(0, 1) == 1);
      endcase
      host_valid = offer;
      host_data  = offer ? beats[bi] : {$urandom, $urandom};
      if (offer && host_ready === 1'b1) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        bi++;
      end
      @(negedge clk);
    end
    total++;
    if (!seen_done) begin bad++; $display("FAIL %s timeout: load_done not seen, words=%0d want %0d", name, nw, TOTAL); end
    total++;
    if (nw !== TOTAL) begin bad++; $display("FAIL %s word_count: got %0d want %0d", name, nw, TOTAL); end
    total++;
    if (dov_first !== acc_cyc + 1) begin
      bad++; $display("FAIL %s latency: first valid cycle %0d, want %0d", name, dov_first, acc_cyc + 1);
    end
    if (mode == 0) begin
      total++;
      if (dov_last - dov_first + 1 !== TOTAL) begin
        bad++; $display("FAIL %s streaming: valid span %0d cycles, want %0d", name, dov_last - dov_first + 1, TOTAL);
      end
    end
    total++;
    if (done_cyc !== dov_last + 1) begin
      bad++; $display("FAIL %s done_timing: load_done at %0d, want %0d", name, done_cyc, dov_last + 1);
    end
    if (!seen_done) begin
      rstn = 1'b0; @(negedge clk); rstn = 1'b1;
    end
    @(negedge clk); start = 1'b0;
    total++;
    if (mode_out !== 1'b1 || busy !== 1'b0 || load_done !== 1'b0 || host_ready !== 1'b0 || data_out_valid !== 1'b0) begin
      bad++; $display("FAIL %s post_done: mode=%b busy=%b done=%b rdy=%b dov=%b, want 1 0 0 0 0",
                      name, mode_out, busy, load_done, host_ready, data_out_valid);
    end
  endtask

  task automatic test_signed();
    logic [15:0] exp4 [4];
    exp4 = '{16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; host_valid = 1'b1; host_data = 64'h8000_7FFF_0001_FFFF;
    total++;
    if (host_ready !== 1'b1) begin bad++; $display("FAIL signed_ready: rdy=%b want 1", host_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); host_valid = 1'b0; host_data = {$urandom, $urandom};
      total++;
      if (data_out_valid !== 1'b1 || para_out !== exp4[i]) begin
        bad++; $display("FAIL signed_lane %0d: dov=%b para=%0d, want 1 %0d", i, data_out_valid, para_out, $signed(exp4[i]));
      end
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (data_out_valid !== 1'b0 || para_out !== 16'sh8000 || mode_out !== 1'b0 || host_ready !== 1'b1) begin
        bad++; $display("FAIL stall_hold: dov=%b para=%0d mode=%b rdy=%b, want 0 -32768 0 1",
                        data_out_valid, para_out, mode_out, host_ready);
      end
    end
    rstn = 1'b0; @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_reset_mid();
    int bi, nw;
    bi = 0; nw = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 2000 && nw < 301; cyc++) begin
      host_valid = 1'b1;
      host_data  = {16'(4*bi+3), 16'(4*bi+2), 16'(4*bi+1), 16'(4*bi)};
      if (host_ready === 1'b1) bi++;
      @(negedge clk);
      if (data_out_valid === 1'b1) begin
        total++;
        if (para_out !== 16'(nw)) begin bad++; $display("FAIL mid_word %0d: got %0d want %0d", nw, para_out, nw); end
        nw++;
      end
    end
    total++;
    if (nw !== 301) begin bad++; $display("FAIL mid_progress: got %0d words want 301", nw); end
    #2 rstn = 1'b0;
    #1;
    total++;
    if (mode_out !== 1'b1 || data_out_valid !== 1'b0 || para_out !== 16'sd0 || busy !== 1'b0 || host_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset: mode=%b dov=%b para=%0d busy=%b rdy=%b, want 1 0 0 0 0",
                      mode_out, data_out_valid, para_out, busy, host_ready);
    end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    total++;
    if (host_ready !== 1'b0 || data_out_valid !== 1'b0 || mode_out !== 1'b1) begin
      bad++; $display("FAIL mid_idle: rdy=%b dov=%b mode=%b, want 0 0 1", host_ready, data_out_valid, mode_out);
    end
    host_valid = 1'b0;
  endtask

  task automatic test_after_done();
    for (int i = 0; i < 20; i++) begin
      host_valid = 1'b1; host_data = {$urandom, $urandom};
      @(negedge clk);
      total++;
      if (host_ready !== 1'b0 || data_out_valid !== 1'b0 || mode_out !== 1'b1 || load_done !== 1'b0) begin
        bad++; $display("FAIL after_done cycle %0d: rdy=%b dov=%b mode=%b done=%b, want 0 0 1 0",
                        i, host_ready, data_out_valid, mode_out, load_done);
      end
    end
    host_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream(0, 1'b0, 1'b0, "back_to_back");
    test_stream(1, 1'b1, 1'b0, "gapped");
    test_signed();
    test_reset_mid();
    test_stream(0, 1'b0, 1'b0, "restart");
    test_stream(2, 1'b1, 1'b1, "start_ignored");
    test_after_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/para_serializer.md
PARA_SERIALIZER -- requirements
Module: para_serializer

Interface
REQ-001 Parameters, one per line:
  IN_WIDTH 64, host beat width.
  PARA_WIDTH 16, parameter word width.
  FM_DEPTH 64, rsign parameter count.
  CHANNEL_NUM 128, per-channel parameter count.
  PARA_NUM 6, parameter groups (1 rsign group + 5 channel groups).
REQ-002 Derived constants, fixed and not overridable:
  LANES = IN_WIDTH/PARA_WIDTH (4).
  TOTAL = FM_DEPTH + (PARA_NUM-1)*CHANNEL_NUM (704).
REQ-003 Ports, one per line: name  direction  width  meaning.
  clk  in  1  sole clock, rising edge.
  rstn  in  1  asynchronous active-low reset.
  start  in  1  begins a load from IDLE.
  host_valid  in  1  host beat valid.
  host_data  in  IN_WIDTH  packed words; lane 0 = bits [PARA_WIDTH-1:0].
  host_ready  out  1  block accepts a beat this cycle.
  para_out  out  PARA_WIDTH signed  serial parameter word to para_loader para_in.
  data_out_valid  out  1  para_out valid; drives para_loader data_in_valid.
  mode_out  out  1  0 = load, 1 = run; drives para_loader mode_in.
  busy  out  1  high in LOAD and DONE.
  load_done  out  1  one-cycle pulse after the final word.
REQ-004 Clock and reset are as stated: one clock, reset asynchronous and active-low.
REQ-005 All outputs SHALL be registered, except host_ready, which is decoded from state.

Function
REQ-006 FSM states SHALL be IDLE, LOAD and DONE.
REQ-007 IDLE: start=1 moves to LOAD and clears the word counter (0..TOTAL-1) and lane counter (0..LANES-1).
REQ-008 start SHALL be ignored in LOAD and DONE.
REQ-009 mode_out SHALL be 0 from the cycle after start is sampled through the cycle carrying the final word, and 1 in every other cycle.
REQ-010 The one-beat buffer is empty, or holds a beat at lane_cnt==LANES-1.
REQ-011 host_ready SHALL be 1 in LOAD when REQ-010 holds and fewer than TOTAL words are issued or buffered; else 0.
REQ-012 Accept on host_valid && host_ready; the beat is latched into the buffer.
REQ-013 Latency: beat accepted at edge N -> lane 0 on para_out with data_out_valid=1 at cycle N+1.
REQ-014 Lanes 1..LANES-1 follow on consecutive cycles, ascending.
REQ-015 A beat accepted while the last lane is presented SHALL give its lane 0 the next cycle, with no bubble (continuous streaming).
REQ-016 data_out_valid SHALL be 0 while the buffer is empty.
REQ-017 para_out SHALL hold its last value when data_out_valid=0.
REQ-018 The word counter SHALL increment once per cycle with data_out_valid=1.
REQ-019 When the word counter reaches TOTAL-1 with data_out_valid=1, go to DONE the next cycle.
REQ-020 Lanes of the final beat beyond TOTAL are discarded; not applicable at defaults (TOTAL divisible by LANES).
REQ-021 DONE lasts exactly one cycle, with load_done=1, mode_out=1 and busy=1; then IDLE.
REQ-022 host_valid in IDLE or DONE SHALL be ignored (host_ready=0).
REQ-023 host_data is only sampled on accept.
REQ-024 The host may drop host_valid at any time; the block then stalls with data_out_valid=0 and keeps all counters.
REQ-025 Word order SHALL be:
  words 0..FM_DEPTH-1 = rsign;
  then CHANNEL_NUM each of bn_a, bn_b, beta, gamma, zeta;
  this matches the downstream counter order.
REQ-026 No arithmetic transformation is applied; para_out bits equal the selected lane bits exactly.

Reset
REQ-027 On rstn=0, immediately and regardless of state:
  state=IDLE; counters=0; buffer empty;
  para_out=0; data_out_valid=0; busy=0; load_done=0; host_ready=0;
  mode_out=1, so the downstream loader is never written during reset.
REQ-028 Reset mid-LOAD SHALL abandon the load; a new start restarts from word 0.

Verification
REQ-029 Bench SHALL cover these directed scenarios:
  (a) Reset, then idle 10 cycles -> mode_out=1, host_ready=0, data_out_valid=0, para_out=0.
  (b) start, then 176 back-to-back beats with lanes 0..703 -> 704 consecutive data_out_valid cycles, para_out=0,1,...,703; mode_out=0 throughout; load_done one cycle after word 703; mode_out=1 after.
  (c) host_valid gapped 2 of every 3 cycles -> the same 704-word sequence with bubbles; word count exact; no duplicated or skipped lane.
  (d) host_data=0x8000_7FFF_0001_FFFF -> para_out -1, 1, 32767, -32768 in that order.
  (e) rstn pulsed low after word 300 -> mode_out=1 immediately; a new start restarts at word 0.
  (f) start asserted during LOAD and during DONE -> ignored; host_valid held high after completion -> host_ready stays 0, no extra data_out_valid.
